// File: rtl/vga_framebuffer_reader.sv
// Pixel fetch between the VGA timing generator and a synchronous framebuffer.
// Maps screen coordinates to addresses, absorbs read latency and formats the DAC colour.
`timescale 1ns/1ps
module vga_framebuffer_reader #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          IMG_W      = 320,
  parameter int          IMG_H      = 240,
  parameter int          SCALE_LOG2 = 1,
  parameter int          X_OFF      = 0,
  parameter int          Y_OFF      = 0,
  parameter int          ADDR_W     = 17,
  parameter int          RD_LAT     = 2,
  parameter logic [7:0]  BORDER     = 8'h00
) (
  input  logic              clk_25,
  input  logic              n_rst,
  input  logic [1:0]        mode,
  input  logic [9:0]        x_coordinate,
  input  logic [9:0]        y_coordinate,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              video_on_in,
  input  logic              synch_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_q,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N
);

  localparam int PIPE   = RD_LAT + 2;
  localparam int IMG_WS = IMG_W << SCALE_LOG2;
  localparam int IMG_HS = IMG_H << SCALE_LOG2;
  localparam int BAR_W  = H_ACTIVE / 8;
  // One spare bit so the post-image increment cannot wrap when IMG_W*IMG_H == 2^ADDR_W.
  localparam int LBW    = ADDR_W + 1;
  localparam logic [11:0] ROW_MASK = 12'((1 << SCALE_LOG2) - 1);

  if (X_OFF + IMG_WS > H_ACTIVE || Y_OFF + IMG_HS > V_ACTIVE || RD_LAT < 1) begin : g_bad_cfg
    $error("vga_framebuffer_reader: image region outside active area or RD_LAT < 1");
  end

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       syn;
    logic       inimg;
    logic [2:0] bar;
    logic [1:0] mode;
  } tag_t;

  localparam tag_t TAG_RST = '{hs: 1'b1, vs: 1'b1, von: 1'b0, syn: 1'b1,
                               inimg: 1'b0, bar: 3'd0, mode: 2'd0};

  logic [11:0]       dx, dy;
  logic [10:0]       col;
  logic              in_x, in_y, in_img, row_last, bar_hit;
  logic [LBW-1:0]    line_base_q, line_base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        bar_q, bar_d;
  logic [1:0]        mode_q, mode_d;
  logic [23:0]       rgb_q, rgb_d;
  tag_t              tag_in, fmt;
  tag_t              pipe_q [PIPE];

  // Signed-style offsets: bit 11 set means the coordinate is left of / above the image.
  assign dx       = {2'b00, x_coordinate} - 12'(X_OFF);
  assign dy       = {2'b00, y_coordinate} - 12'(Y_OFF);
  assign in_x     = ~dx[11] & (dx[10:0] < 11'(IMG_WS));
  assign in_y     = ~dy[11] & (dy[10:0] < 11'(IMG_HS));
  assign in_img   = in_x & in_y;
  assign col      = dx[10:0] >> SCALE_LOG2;
  assign row_last = (dy & ROW_MASK) == ROW_MASK;

  always_comb begin
    mem_addr_d = mem_addr_q;
    if (in_img) mem_addr_d = ADDR_W'(line_base_q + LBW'(col));

    line_base_d = line_base_q;
    if (y_coordinate >= 10'(V_ACTIVE))
      line_base_d = '0;
    else if (x_coordinate == 10'(H_ACTIVE - 1) && in_y && row_last)
      line_base_d = line_base_q + LBW'(IMG_W);

    mode_d = mode_q;
    if (x_coordinate == 10'd0 && y_coordinate == 10'(V_ACTIVE)) mode_d = mode;

    bar_hit = 1'b0;
    for (int k = 1; k < 8; k++)
      if (x_coordinate == 10'(k * BAR_W)) bar_hit = 1'b1;
    bar_d = bar_q;
    if (x_coordinate == 10'd0)          bar_d = 3'd0;
    else if (bar_hit && bar_q != 3'd7)  bar_d = bar_q + 3'd1;

    tag_in = '{hs: hsync_in, vs: vsync_in, von: video_on_in, syn: synch_in,
               inimg: in_img, bar: bar_d, mode: mode_q};
  end

  // Stage PIPE-2 lines up with mem_q; the colour register adds the final stage.
  assign fmt = pipe_q[PIPE-2];

  always_comb begin
    rgb_d = '0;
    if (fmt.von) begin
      if (fmt.mode == 2'd2)
        rgb_d = {{8{fmt.bar[2]}}, {8{fmt.bar[1]}}, {8{fmt.bar[0]}}};
      else if (!fmt.inimg)
        rgb_d = {3{BORDER}};
      else begin
        case (fmt.mode)
          2'd1:    rgb_d = {mem_q[7:5], mem_q[7:5], mem_q[7:6],
                            mem_q[4:2], mem_q[4:2], mem_q[4:3],
                            {4{mem_q[1:0]}}};
          2'd3:    rgb_d = {3{~mem_q}};
          default: rgb_d = {3{mem_q}};
        endcase
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      mem_addr_q  <= '0;
      line_base_q <= '0;
      bar_q       <= '0;
      mode_q      <= '0;
      rgb_q       <= '0;
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= TAG_RST;
    end else begin
      mem_addr_q  <= mem_addr_d;
      line_base_q <= line_base_d;
      bar_q       <= bar_d;
      mode_q      <= mode_d;
      rgb_q       <= rgb_d;
      pipe_q[0]   <= tag_in;
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign mem_addr    = mem_addr_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = pipe_q[PIPE-1].hs;
  assign VGA_VS      = pipe_q[PIPE-1].vs;
  assign VGA_BLANK_N = pipe_q[PIPE-1].von;
  assign VGA_SYNC_N  = pipe_q[PIPE-1].syn;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Scoreboard bench: default instance plus an offset/1x instance with a visible border.
`timescale 1ns/1ps
module tb_vga_framebuffer_reader;
  localparam int PIPE = 4;

  logic        clk_25 = 1'b0;
  logic        n_rst  = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [9:0]  x_i = '0, y_i = '0;
  logic        hs_i = 1'b1, vs_i = 1'b1, von_i = 1'b0, sy_i = 1'b1;
  logic [16:0] addr0, addr1;
  logic [7:0]  q0, q1, m0, m1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, bl0, sn0, hs1, vs1, bl1, sn1;

  always #20 clk_25 = ~clk_25;

  vga_framebuffer_reader u0 (
    .clk_25(clk_25), .n_rst(n_rst), .mode(mode_i), .x_coordinate(x_i), .y_coordinate(y_i),
    .hsync_in(hs_i), .vsync_in(vs_i), .video_on_in(von_i), .synch_in(sy_i),
    .mem_addr(addr0), .mem_q(q0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
    .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bl0), .VGA_SYNC_N(sn0));

  vga_framebuffer_reader #(.X_OFF(160), .Y_OFF(120), .SCALE_LOG2(0), .BORDER(8'h5A)) u1 (
    .clk_25(clk_25), .n_rst(n_rst), .mode(mode_i), .x_coordinate(x_i), .y_coordinate(y_i),
    .hsync_in(hs_i), .vsync_in(vs_i), .video_on_in(von_i), .synch_in(sy_i),
    .mem_addr(addr1), .mem_q(q1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bl1), .VGA_SYNC_N(sn1));

  // Two-cycle synchronous memories whose contents are addr[7:0].
  always @(posedge clk_25) begin
    m0 <= addr0[7:0]; q0 <= m0;
    m1 <= addr1[7:0]; q1 <= m1;
  end

  typedef struct {
    int          due;
    bit          chk_rgb;
    logic [23:0] rgb0, rgb1;
    logic        hs, vs, bl, sy;
  } pexp_t;
  typedef struct {
    int due;
    bit c0, c1;
    int a0, a1;
  } aexp_t;

  pexp_t qp[$];
  aexp_t qa[$];
  int cyc = 0, n_chk = 0, n_fail = 0, flush = 0, mode_cur = 0;

  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit img(int x, int y, int xo, int yo, int s);
    return x >= xo && x < xo + (320 << s) && y >= yo && y < yo + (240 << s);
  endfunction

  function automatic int addr_of(int x, int y, int xo, int yo, int s);
    return ((y - yo) >> s) * 320 + ((x - xo) >> s);
  endfunction

  function automatic logic [23:0] pix(int x, int y, bit von, int md, int xo, int yo, int s,
                                      logic [7:0] bord);
    logic [7:0] d;
    int a, b;
    if (!von) return 24'h0;
    if (md == 2) begin
      b = x / 80;
      if (b > 7) b = 7;
      return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    end
    if (!img(x, y, xo, yo, s)) return {bord, bord, bord};
    a = addr_of(x, y, xo, yo, s);
    d = a[7:0];
    case (md)
      0:       return {d, d, d};
      1:       return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
      default: return {~d, ~d, ~d};
    endcase
  endfunction

  always @(negedge clk_25) begin : mon
    pexp_t pe;
    aexp_t ae;
    int pi, ai;
    pi = -1;
    for (int i = 0; i < qp.size(); i++) if (pi < 0 && qp[i].due == cyc) pi = i;
    if (pi >= 0) begin
      pe = qp[pi];
      qp.delete(pi);
      chk("hs0", 32'(hs0), 32'(pe.hs));   chk("hs1", 32'(hs1), 32'(pe.hs));
      chk("vs0", 32'(vs0), 32'(pe.vs));   chk("vs1", 32'(vs1), 32'(pe.vs));
      chk("blank0", 32'(bl0), 32'(pe.bl)); chk("blank1", 32'(bl1), 32'(pe.bl));
      chk("sync0", 32'(sn0), 32'(pe.sy)); chk("sync1", 32'(sn1), 32'(pe.sy));
      if (pe.chk_rgb) begin
        chk("rgb0", 32'({r0, g0, b0}), 32'(pe.rgb0));
        chk("rgb1", 32'({r1, g1, b1}), 32'(pe.rgb1));
      end
    end
    ai = -1;
    for (int i = 0; i < qa.size(); i++) if (ai < 0 && qa[i].due == cyc) ai = i;
    if (ai >= 0) begin
      ae = qa[ai];
      qa.delete(ai);
      if (ae.c0) chk("addr0", 32'(addr0), ae.a0);
      if (ae.c1) chk("addr1", 32'(addr1), ae.a1);
    end
  end

  task automatic push_rst(bit with_addr);
    pexp_t pe;
    aexp_t ae;
    pe.due = cyc + 1; pe.chk_rgb = 1'b1; pe.rgb0 = '0; pe.rgb1 = '0;
    pe.hs = 1'b1; pe.vs = 1'b1; pe.bl = 1'b0; pe.sy = 1'b1;
    qp.push_back(pe);
    if (with_addr) begin
      ae.due = cyc + 1; ae.c0 = 1'b1; ae.c1 = 1'b1; ae.a0 = 0; ae.a1 = 0;
      qa.push_back(ae);
    end
  endtask

  task automatic do_reset(int x, int y, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_25); #1;
      if (k == 0)
        for (int i = qp.size() - 1; i >= 0; i--) if (qp[i].due > cyc) qp.delete(i);
      n_rst = 1'b0; x_i = 10'(x); y_i = 10'(y);
      hs_i = 1'($urandom); vs_i = 1'($urandom); sy_i = 1'($urandom); von_i = 1'b1;
      push_rst(1'b1);
    end
    mode_cur = 0;
    flush = PIPE - 1;
  endtask

  task automatic drive(int x, int y, bit full);
    pexp_t pe;
    aexp_t ae;
    @(posedge clk_25); #1;
    n_rst = 1'b1; x_i = 10'(x); y_i = 10'(y);
    hs_i = 1'($urandom); vs_i = 1'($urandom); sy_i = 1'($urandom);
    von_i = (x < 640 && y < 480) && ($urandom_range(0, 7) != 0);
    if (flush > 0) begin
      push_rst(1'b0);
      flush--;
    end
    ae.due = cyc + 1;
    ae.c0 = img(x, y, 0, 0, 1);
    ae.c1 = img(x, y, 160, 120, 0);
    ae.a0 = addr_of(x, y, 0, 0, 1);
    ae.a1 = addr_of(x, y, 160, 120, 0);
    if (ae.c0 || ae.c1) qa.push_back(ae);
    pe.due = cyc + PIPE;
    pe.chk_rgb = (mode_cur != 2) || full || !von_i;
    pe.rgb0 = pix(x, y, von_i, mode_cur, 0, 0, 1, 8'h00);
    pe.rgb1 = pix(x, y, von_i, mode_cur, 160, 120, 0, 8'h5A);
    pe.hs = hs_i; pe.vs = vs_i; pe.bl = von_i; pe.sy = sy_i;
    qp.push_back(pe);
    if (x == 0 && y == 480) mode_cur = int'(mode_i);
  endtask

  // Rows are scanned sparsely but always end at x=639 so the line base advances.
  task automatic frame(int full_rows, int sw_row, int sw_mode, int rst_row);
    int r;
    for (int y = 0; y < 480; y++) begin
      if (y == sw_row) mode_i = 2'(sw_mode);
      if (y == rst_row) begin
        drive(0, y, 1'b0);
        drive(300, y, 1'b0);
        do_reset(301, y, 5);
        break;
      end
      if (y < full_rows) begin
        for (int x = 0; x < 640; x++) drive(x, y, 1'b1);
      end else begin
        drive(0, y, 1'b0);   drive(6, y, 1'b0);   drive(56, y, 1'b0);
        drive(159, y, 1'b0); drive(160, y, 1'b0); drive(292, y, 1'b0);
        drive(448, y, 1'b0);
        repeat (3) begin
          r = $urandom_range(0, 798);
          if (r >= 639) r++;
          drive(r, y, 1'b0);
        end
        drive(639, y, 1'b0);
      end
    end
    drive(0, 480, 1'b0);
    drive(639, 480, 1'b0);
    drive($urandom_range(0, 799), $urandom_range(481, 524), 1'b0);
  endtask

  initial begin
    do_reset(0, 480, 5);
    frame(0, 100, 1, -1);   // gray, switch to RGB332 for next frame
    frame(0, 100, 2, -1);   // RGB332, request bars mid-frame
    frame(3, 100, 3, -1);   // colour bars, full rows at the top
    frame(0, -1, 0, 200);   // inverted gray, reset mid-frame
    frame(0, 100, 0, -1);   // inverted gray after reset
    repeat (PIPE + 2) @(posedge clk_25);
    @(negedge clk_25); #1;
    foreach (qp[i]) begin
      n_chk++; n_fail++;
      $display("FAIL pixel_timeout due=%0d now=%0d", qp[i].due, cyc);
    end
    foreach (qa[i]) begin
      n_chk++; n_fail++;
      $display("FAIL addr_timeout due=%0d now=%0d", qa[i].due, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer_reader.md
Name: vga_framebuffer_reader

Overview:
Parametrised pixel-fetch pipeline between vga_controller and a synchronous framebuffer ROM/RAM. It maps screen coordinates to framebuffer addresses for an image of configurable size, offset and integer power-of-two upscale, without using a multiplier. It absorbs the memory read latency and delays sync/blank so they stay aligned with the pixel. It formats pixels as grayscale, RGB332, inverted grayscale or an internal colour-bar test pattern, and drives the VGA DAC pins directly.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
IMG_W, 320, stored image width in pixels
IMG_H, 240, stored image height in lines
SCALE_LOG2, 1, each stored pixel is repeated 2^SCALE_LOG2 times horizontally and vertically
X_OFF, 0, screen x of image left edge
Y_OFF, 0, screen y of image top edge
ADDR_W, 17, framebuffer address width (2^ADDR_W >= IMG_W*IMG_H)
RD_LAT, 2, memory read latency in cycles (>=1)
BORDER, 8'h00, gray level outside the image in modes 0/1/3

Ports:
clk_25  in  1  pixel clock
n_rst  in  1  synchronous active-low reset
mode  in  2  0 gray, 1 RGB332, 2 colour bars, 3 inverted gray
x_coordinate  in  10  controller x, counts the full line including blanking
y_coordinate  in  10  controller y, counts the full frame including blanking
hsync_in  in  1  controller hsync
vsync_in  in  1  controller vsync
video_on_in  in  1  controller active-video flag
synch_in  in  1  controller composite sync_n
mem_addr  out  ADDR_W  framebuffer read address, registered
mem_q  in  8  framebuffer data, valid RD_LAT cycles after mem_addr
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
VGA_HS, VGA_VS  out  1  delayed syncs
VGA_BLANK_N  out  1  delayed video_on
VGA_SYNC_N  out  1  delayed synch

Behaviour:
- Reset (n_rst=0 at a clk_25 edge): mem_addr=0, RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_SYNC_N=1, line_base=0, mode_q=0, bar counter=0. Every delay-line stage resets to these values. Reset mid-frame takes effect on the next edge. Outputs become valid again PIPE cycles after release.
- Latency: PIPE = RD_LAT+2. Coordinate at edge t -> mem_addr at t+1 -> mem_q at t+1+RD_LAT -> registered outputs at t+PIPE. hs, vs, video_on, synch, the in-image flag, the bar colour and mode_q all pass through identical PIPE-deep shift registers.
- Image region: in_img = X_OFF <= x < X_OFF+(IMG_W<<SCALE_LOG2) and Y_OFF <= y < Y_OFF+(IMG_H<<SCALE_LOG2). The region must lie inside H_ACTIVE x V_ACTIVE; the team checks this at elaboration.
- Address: mem_addr <= line_base + ((x-X_OFF)>>SCALE_LOG2) when in_img. When not in_img, mem_addr holds its previous value.
- line_base: cleared while y >= V_ACTIVE. At x==H_ACTIVE-1 on an image row whose low SCALE_LOG2 bits of (y-Y_OFF) are all ones, line_base += IMG_W. This rule makes a 1x scale increment on every row. Final line_base never exceeds IMG_W*IMG_H.
- mode_q: latched from mode only at x==0 && y==V_ACTIVE, so there is no mid-frame tearing.
- Bar counter b (3 bits): cleared at x==0. It increments each time x reaches a multiple of H_ACTIVE/8 (x>0, x<H_ACTIVE) and saturates at 7.
- Output format, registered, with d=mem_q:
  - Mode 0: R=G=B=d.
  - Mode 1: R={d[7:5],d[7:5],d[7:6]}, G={d[4:2],d[4:2],d[4:3]}, B={d[1:0],d[1:0],d[1:0],d[1:0]}.
  - Mode 2: R={8{b[2]}}, G={8{b[1]}}, B={8{b[0]}}, over the whole active area, ignoring in_img.
  - Mode 3: R=G=B=~d.
  - Modes 0/1/3 outside in_img: R=G=B=BORDER.
  - Delayed video_on=0: RGB=0 regardless of mode.
- Simultaneous events: the line_base clear has priority over the increment. Reset has priority over everything.

Test Plan:
- Reset: n_rst=0 for 5 cycles mid-line -> RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_SYNC_N=1, mem_addr=0. After release, valid pixels appear exactly 4 cycles later (defaults).
- Address walk, defaults:
  - y=0, x=0..3 -> mem_addr 0,0,1,1.
  - y=1, x=2 -> 1 (row repeat).
  - y=2, x=0 -> 320.
  - y=479, x=639 -> 76799.
  - Next frame y=0, x=0 -> 0.
- Latency/alignment: memory model returns q=addr[7:0] with RD_LAT=2. hsync_in low at edge t -> VGA_HS low at t+4. x=6, y=0 gray -> RGB=0x03 on the same cycle as that sync alignment.
- RGB332 (mode 1) mem_q expansion:
  - 0xE0 -> FF/00/00.
  - 0x1C -> 00/FF/00.
  - 0x03 -> 00/00/FF.
  - 0x92 -> 92/92/AA.
- Offset/border: X_OFF=160, Y_OFF=120, SCALE_LOG2=0.
  - x=159, y=120 -> RGB=BORDER.
  - x=160, y=120 -> mem_addr 0.
  - x=160, y=121 -> 320.
  - video_on_in=0 -> RGB=0.
- Mode switch: mode 0->2 at y=100 -> frame unchanged. Next frame:
  - x=0..79 -> 000000.
  - x=80 -> 0000FF.
  - x=560..639 -> FFFFFF.
  - Mid-frame reset -> outputs return to reset values.
